// File: rtl/prescaled_counter_if.sv
// Control and status bundle for prescaled_counter.
// The master drives the controls and observes the count and status.
// The slave is the counter itself.
interface prescaled_counter_if #(
  parameter int WIDTH    = 8,
  parameter int PS_WIDTH = 32
);
  logic                enable;
  logic                load;
  logic [WIDTH-1:0]    load_value;
  logic                up_down;
  logic                one_shot;
  logic [PS_WIDTH-1:0] prescaler_val;
  logic [WIDTH-1:0]    counter;
  logic                step;
  logic                terminal;
  logic                overflow;
  logic                done;

  modport master (
    output enable, load, load_value, up_down, one_shot, prescaler_val,
    input  counter, step, terminal, overflow, done
  );

  modport slave (
    input  enable, load, load_value, up_down, one_shot, prescaler_val,
    output counter, step, terminal, overflow, done
  );
endinterface

// File: rtl/prescaled_counter.sv
// Up/down counter with a programmable prescaler, synchronous load and
// wrap or one-shot behaviour. It provides step and terminal pulses, a sticky
// overflow flag and a done flag. All outputs are registered.
module prescaled_counter #(
  parameter int               WIDTH       = 8,
  parameter int               PS_WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic              clock,
  input logic              reset_n,
  prescaled_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_n;
  logic [WIDTH-1:0]    cnt, cnt_n;
  logic [PS_WIDTH-1:0] ps, ps_n;
  logic                step_q, step_n;
  logic                term_q, term_n;
  logic                ovf_q, ovf_n;
  logic                done_q, done_n;
  logic                at_term;

  // State, count, prescaler and registered status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= RESET_VALUE;
      ps     <= '0;
      step_q <= 1'b0;
      term_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ps     <= ps_n;
      step_q <= step_n;
      term_q <= term_n;
      ovf_q  <= ovf_n;
      done_q <= done_n;
    end
  end

  // Next-state and next-output logic. Load overrides everything, and a low
  // enable in RUN overrides a pending step edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ps_n    = ps;
    ovf_n   = ovf_q;
    step_n  = 1'b0;
    term_n  = 1'b0;
    at_term = bus.up_down ? (cnt == '1) : (cnt == '0);

    if (bus.load) begin
      cnt_n   = bus.load_value;
      ps_n    = '0;
      ovf_n   = 1'b0;
      state_n = bus.enable ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          ps_n = '0;
          if (bus.enable) state_n = RUN;
        end
        RUN: begin
          if (!bus.enable) begin
            ps_n    = '0;
            state_n = IDLE;
          end else if (ps >= bus.prescaler_val) begin
            ps_n = '0;
            if (at_term) begin
              term_n = 1'b1;
              if (bus.one_shot) begin
                state_n = DONE;
              end else begin
                cnt_n  = bus.up_down ? '0 : '1;
                ovf_n  = 1'b1;
                step_n = 1'b1;
              end
            end else begin
              cnt_n  = bus.up_down ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
              step_n = 1'b1;
            end
          end else begin
            ps_n = ps + PS_WIDTH'(1);
          end
        end
        DONE: begin
          ps_n = '0;
          if (!bus.enable) state_n = IDLE;
        end
        default: begin
          ps_n    = '0;
          state_n = IDLE;
        end
      endcase
    end

    done_n = (state_n == DONE);
  end

  assign bus.counter  = cnt;
  assign bus.step     = step_q;
  assign bus.terminal = term_q;
  assign bus.overflow = ovf_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Randomized and directed bench for prescaled_counter. A behavioural
// integer model predicts every output after each clock.
module tb_prescaled_counter;

  localparam int W    = 8;
  localparam int PW   = 8;
  localparam int MAXV = (1 << W) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  prescaled_counter_if #(.WIDTH(W), .PS_WIDTH(PW)) bus ();

  prescaled_counter #(
    .WIDTH(W),
    .PS_WIDTH(PW),
    .RESET_VALUE(8'h00)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: plain integers, mode flags for running / finished
  int m_cnt, m_ps;
  bit m_run, m_fin, m_ovf, m_step, m_term;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ps = 0; m_run = 0; m_fin = 0; m_ovf = 0; m_step = 0; m_term = 0;
  endtask

  task automatic model_clock(input bit en, input bit ld, input int lv,
                             input bit ud, input bit os, input int pv);
    int limit;
    m_step = 0;
    m_term = 0;
    if (ld) begin
      m_cnt = lv; m_ps = 0; m_ovf = 0; m_fin = 0; m_run = en;
    end else if (m_fin) begin
      if (!en) m_fin = 0;
    end else if (!m_run) begin
      m_run = en;
      m_ps  = 0;
    end else if (!en) begin
      m_run = 0;
      m_ps  = 0;
    end else if (m_ps >= pv) begin
      m_ps  = 0;
      limit = ud ? MAXV : 0;
      if (m_cnt == limit) begin
        m_term = 1;
        if (os) begin
          m_fin = 1;
          m_run = 0;
        end else begin
          m_cnt  = ud ? 0 : MAXV;
          m_ovf  = 1;
          m_step = 1;
        end
      end else begin
        m_cnt  = (m_cnt + (ud ? 1 : -1) + MAXV + 1) % (MAXV + 1);
        m_step = 1;
      end
    end else begin
      m_ps++;
    end
  endtask

  task automatic compare_all();
    check("counter",  32'(bus.counter),  32'(m_cnt));
    check("step",     32'(bus.step),     32'(m_step));
    check("terminal", 32'(bus.terminal), 32'(m_term));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("done",     32'(bus.done),     32'(m_fin));
  endtask

  // Called at a falling edge: apply inputs, predict, clock, then compare.
  task automatic tick(input bit en, input bit ld, input logic [W-1:0] lv,
                      input bit ud, input bit os, input logic [PW-1:0] pv);
    bus.enable = en; bus.load = ld; bus.load_value = lv;
    bus.up_down = ud; bus.one_shot = os; bus.prescaler_val = pv;
    model_clock(en, ld, int'(lv), ud, os, int'(pv));
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  initial begin
    bit ud, os;
    logic [W-1:0] lv;
    bus.enable = 0; bus.load = 0; bus.load_value = '0;
    bus.up_down = 1; bus.one_shot = 0; bus.prescaler_val = '0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    reset_n = 1'b1;

    // Free-running up count with wrap
    repeat (257) tick(1, 0, 8'h00, 1, 0, 8'd0);
    check("wrap_term", 32'(bus.terminal), 32'd1);
    check("wrap_cnt",  32'(bus.counter),  32'd0);
    check("wrap_ovf",  32'(bus.overflow), 32'd1);

    // Load coinciding with a step edge
    tick(1, 1, 8'hAA, 1, 0, 8'd0);
    check("ld_cnt",  32'(bus.counter),  32'hAA);
    check("ld_step", 32'(bus.step),     32'd0);
    check("ld_ovf",  32'(bus.overflow), 32'd0);

    // Prescaled stepping every 4th clock
    repeat (12) tick(1, 0, 8'h00, 1, 0, 8'd3);

    // One-shot down count to zero
    tick(1, 1, 8'h05, 0, 1, 8'd0);
    repeat (10) tick(1, 0, 8'h00, 0, 1, 8'd0);
    check("os_done", 32'(bus.done),    32'd1);
    check("os_cnt",  32'(bus.counter), 32'd0);

    // Runtime decrease of prescaler_val below the running prescaler
    tick(1, 1, 8'h10, 1, 0, 8'd20);
    repeat (10) tick(1, 0, 8'h00, 1, 0, 8'd20);
    tick(1, 0, 8'h00, 1, 0, 8'd4);
    check("ps_drop_step", 32'(bus.step), 32'd1);
    repeat (12) tick(1, 0, 8'h00, 1, 0, 8'd4);

    // Asynchronous reset in the middle of a clock phase while running
    tick(1, 1, 8'h7F, 1, 0, 8'd0);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_cnt",  32'(bus.counter),  32'd0);
    check("arst_step", 32'(bus.step),     32'd0);
    check("arst_term", 32'(bus.terminal), 32'd0);
    check("arst_done", 32'(bus.done),     32'd0);
    model_reset();
    @(negedge clock);
    compare_all();
    reset_n = 1'b1;

    // Randomized traffic, biased toward terminal values
    ud = 1; os = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) ud = ~ud;
      if ($urandom_range(0, 127) == 0) os = ~os;
      case ($urandom_range(0, 3))
        0: lv = 8'hFD;
        1: lv = 8'h02;
        default: lv = W'($urandom);
      endcase
      tick($urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0, lv, ud, os,
           PW'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
